instr_encoder: RTL and testbench

// - Inverse of the instruction decoder: takes decoded fields (opcode class, operands, ALU mode, immediate)
//   and emits the 8-bit instruction byte stream into program memory.
// - Sits between the host/boot loader and the program RAM write port.
// - Used for in-system program loading and for round-trip checking against the decoder.

---
 rtl/instr_encoder_pkg.sv | 74 +++++++
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared symbols for the instruction encoder:
//   - OP_*  : opcode class codes presented on in_opcode
//   - ALU_* : ALU mode codes carried in the low nibble of an ALU instruction
//   - REG_* : register field codes for operand1/operand2
//   - ENC_* : base byte for each class; operand fields are ORed into it
//   - ST_*  : FSM state encodings for the encoder top
//   - pack_t: result of packing one field tuple into an instruction byte
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ALU  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_LDI  = 8'h03;
    localparam logic [7:0] OP_LDX  = 8'h04;
    localparam logic [7:0] OP_STX  = 8'h05;
    localparam logic [7:0] OP_PUSH = 8'h06;
    localparam logic [7:0] OP_POP  = 8'h07;
    localparam logic [7:0] OP_LDA  = 8'h08;
    localparam logic [7:0] OP_STA  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0A;
    localparam logic [7:0] OP_JMP  = 8'h0B;
    localparam logic [7:0] OP_CALL = 8'h0C;
    localparam logic [7:0] OP_RET  = 8'h0D;
    localparam logic [7:0] OP_HLT  = 8'h0E;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_SHR = 4'h6;
    localparam logic [3:0] ALU_NOT = 4'h7;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;
    localparam logic [2:0] REG_R2 = 3'd2;
    localparam logic [2:0] REG_R3 = 3'd3;
    localparam logic [2:0] REG_R4 = 3'd4;
    localparam logic [2:0] REG_R5 = 3'd5;
    localparam logic [2:0] REG_R6 = 3'd6;
    localparam logic [2:0] REG_R7 = 3'd7;

    // Base bytes leave the low bits clear wherever a class carries fields.
    localparam logic [7:0] ENC_NOP  = 8'h00;
    localparam logic [7:0] ENC_MOV  = 8'h40;
    localparam logic [7:0] ENC_ALU  = 8'h80;
    localparam logic [7:0] ENC_LDI  = 8'h90;
    localparam logic [7:0] ENC_LDX  = 8'h98;
    localparam logic [7:0] ENC_STX  = 8'hA0;
    localparam logic [7:0] ENC_PUSH = 8'hA8;
    localparam logic [7:0] ENC_POP  = 8'hB0;
    localparam logic [7:0] ENC_LDA  = 8'hB8;
    localparam logic [7:0] ENC_STA  = 8'hC0;
    localparam logic [7:0] ENC_CMP  = 8'hC8;
    localparam logic [7:0] ENC_JMP  = 8'hC9;
    localparam logic [7:0] ENC_CALL = 8'hCA;
    localparam logic [7:0] ENC_RET  = 8'hCB;
    localparam logic [7:0] ENC_HLT  = 8'hFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP   = 2'd1;
    localparam logic [1:0] ST_IMM  = 2'd2;

    typedef struct packed {
        logic [7:0] enc_byte;
        logic       two_byte;
        logic       illegal;
    } pack_t;

endpackage

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the field-tuple handshake, address load and program RAM write port
// of the instruction encoder.
//   master : host / boot loader side (also plays the RAM, driving mem_ready)
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    import instr_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [2:0]        in_operand1;
    logic [2:0]        in_operand2;
    logic [3:0]        in_alu_mode;
    logic [7:0]        in_imm;
    logic              set_addr;
    logic [ADDR_W-1:0] addr_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic              err_illegal;
    logic              wrapped;

    modport master (
        output in_valid, in_opcode, in_operand1, in_operand2, in_alu_mode, in_imm,
               set_addr, addr_in, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, err_illegal, wrapped
    );

    modport slave (
        input  in_valid, in_opcode, in_operand1, in_operand2, in_alu_mode, in_imm,
               set_addr, addr_in, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, err_illegal, wrapped
    );

endinterface

// File: rtl/instr_pack.sv
// ----------------------------------------------------------------------------
// instr_pack
// Purely combinational: turns one decoded field tuple into its first
// instruction byte and flags whether an immediate byte follows or whether the
// opcode class is unknown.
//   opcode, operand1, operand2, alu_mode : decoded fields
//   result                               : {enc_byte, two_byte, illegal}
// ----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [2:0] operand1,
    input  logic [2:0] operand2,
    input  logic [3:0] alu_mode,
    output pack_t      result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ALU:  result.enc_byte = ENC_ALU  | {4'h0, alu_mode};
            OP_MOV:  result.enc_byte = ENC_MOV  | {2'b00, operand1, operand2};
            OP_LDI:  begin
                result.enc_byte = ENC_LDI | {5'b0, operand2};
                result.two_byte = 1'b1;
            end
            OP_LDX:  result.enc_byte = ENC_LDX  | {5'b0, operand2};
            OP_STX:  result.enc_byte = ENC_STX  | {5'b0, operand2};
            OP_PUSH: result.enc_byte = ENC_PUSH | {5'b0, operand2};
            OP_POP:  result.enc_byte = ENC_POP  | {5'b0, operand2};
            OP_LDA:  begin
                result.enc_byte = ENC_LDA | {5'b0, operand2};
                result.two_byte = 1'b1;
            end
            OP_STA:  begin
                result.enc_byte = ENC_STA | {5'b0, operand2};
                result.two_byte = 1'b1;
            end
            OP_CMP:  result.enc_byte = ENC_CMP;
            OP_JMP:  begin
                result.enc_byte = ENC_JMP;
                result.two_byte = 1'b1;
            end
            OP_CALL: begin
                result.enc_byte = ENC_CALL;
                result.two_byte = 1'b1;
            end
            OP_RET:  result.enc_byte = ENC_RET;
            OP_NOP:  result.enc_byte = ENC_NOP;
            OP_HLT:  result.enc_byte = ENC_HLT;
            default: result.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Accepts decoded instruction fields and writes the resulting one- or two-byte
// instruction into program RAM at an auto-incrementing address.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of instr_encoder_if (field handshake, address load,
//              RAM write port, sticky err_illegal / wrapped flags)
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [7:0]        op_byte;
    logic [7:0]        imm_reg;
    logic              two_byte_reg;
    logic [ADDR_W-1:0] addr;
    logic              err_reg;
    logic              wrapped_reg;
    pack_t             packed_fields;

    instr_pack u_pack (
        .opcode   (bus.in_opcode),
        .operand1 (bus.in_operand1),
        .operand2 (bus.in_operand2),
        .alu_mode (bus.in_alu_mode),
        .result   (packed_fields)
    );

    // An address load in IDLE wins over a tuple, so the tuple is refused that cycle.
    assign bus.in_ready    = (state == ST_IDLE) && !bus.set_addr;
    assign bus.mem_we      = (state == ST_OP) || (state == ST_IMM);
    assign bus.mem_addr    = addr;
    assign bus.err_illegal = err_reg;
    assign bus.wrapped     = wrapped_reg;

    always_comb begin
        bus.mem_wdata = 8'h00;
        if (state == ST_OP) begin
            bus.mem_wdata = op_byte;
        end else if (state == ST_IMM) begin
            bus.mem_wdata = imm_reg;
        end
    end

    // Every byte leaves the RAM port only when mem_ready is seen; until then
    // the state, address and latched bytes simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_byte      <= 8'h00;
            imm_reg      <= 8'h00;
            two_byte_reg <= 1'b0;
            addr         <= START_ADDR;
            err_reg      <= 1'b0;
            wrapped_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.set_addr) begin
                        addr <= bus.addr_in;
                    end else if (bus.in_valid) begin
                        if (packed_fields.illegal) begin
                            err_reg <= 1'b1;
                        end else begin
                            op_byte      <= packed_fields.enc_byte;
                            imm_reg      <= bus.in_imm;
                            two_byte_reg <= packed_fields.two_byte;
                            state        <= ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    if (bus.mem_ready) begin
                        addr <= addr + ADDR_ONE;
                        if (addr == {ADDR_W{1'b1}}) begin
                            wrapped_reg <= 1'b1;
                        end
                        state <= two_byte_reg ? ST_IMM : ST_IDLE;
                    end
                end
                ST_IMM: begin
                    if (bus.mem_ready) begin
                        addr <= addr + ADDR_ONE;
                        if (addr == {ADDR_W{1'b1}}) begin
                            wrapped_reg <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
// Directed scenarios plus a randomized run of the instruction encoder. The
// expected byte stream comes from a table-driven reference model of the
// instruction set; a monitor records every byte the RAM accepts.
// ----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct packed {
        logic [7:0] op;
        logic [2:0] o1;
        logic [2:0] o2;
        logic [3:0] mode;
        logic [7:0] imm;
    } tuple_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.ADDR_W(8), .START_ADDR(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Bytes the RAM actually took, as {addr, data}.
    logic [15:0] obs_q[$];
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1)
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    // Reference model: per opcode code 0..14 the base byte, which fields it
    // carries (0 none, 1 alu mode, 2 op1+op2, 3 op2) and its length in bytes.
    logic [7:0] base_tab [15] = '{8'h00, 8'h80, 8'h40, 8'h90, 8'h98, 8'hA0, 8'hA8, 8'hB0,
                                  8'hB8, 8'hC0, 8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hFF};
    int kind_tab [15] = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0};
    int len_tab  [15] = '{1, 1, 1, 2, 1, 1, 1, 1, 2, 2, 1, 2, 2, 1, 1};

    logic [7:0]  m_addr;
    bit          m_wrapped;
    bit          m_err;
    logic [15:0] exp_q[$];

    function automatic void model_write(input logic [7:0] b);
        exp_q.push_back({m_addr, b});
        if (m_addr == 8'hFF) m_wrapped = 1'b1;
        m_addr = m_addr + 8'd1;
    endfunction

    function automatic void model_accept(input tuple_t t);
        int idx;
        logic [7:0] b;
        idx = int'(t.op);
        if (idx > 14) begin
            m_err = 1'b1;
            return;
        end
        case (kind_tab[idx])
            1:       b = base_tab[idx] + 8'(t.mode);
            2:       b = base_tab[idx] + 8'(t.o1) * 8'd8 + 8'(t.o2);
            3:       b = base_tab[idx] + 8'(t.o2);
            default: b = base_tab[idx];
        endcase
        model_write(b);
        if (len_tab[idx] == 2) model_write(t.imm);
    endfunction

    function automatic tuple_t mk(input logic [7:0] op, input logic [2:0] o1, input logic [2:0] o2,
                                  input logic [3:0] mode, input logic [7:0] imm);
        tuple_t t;
        t.op = op; t.o1 = o1; t.o2 = o2; t.mode = mode; t.imm = imm;
        return t;
    endfunction

    task automatic drive_fields(input tuple_t t);
        bus.in_opcode   = t.op;
        bus.in_operand1 = t.o1;
        bus.in_operand2 = t.o2;
        bus.in_alu_mode = t.mode;
        bus.in_imm      = t.imm;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.set_addr  = 1'b0;
        bus.addr_in   = 8'h00;
        bus.mem_ready = 1'b0;
        drive_fields(mk(8'h00, 3'd0, 3'd0, 4'd0, 8'h00));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        obs_q.delete();
    endtask

    // Presents a tuple until the handshake completes; returns just after the accepting edge.
    task automatic send(input tuple_t t, input string name);
        bit ok = 1'b0;
        drive_fields(t);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s_accept: handshake never completed, in_ready=%b required 1", name, bus.in_ready);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b0 && bus.in_ready === 1'b1) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s_idle: encoder never returned idle, mem_we=%b required 0", name, bus.mem_we);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total += 6;
        if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        if (bus.mem_addr !== 8'h00) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
        if (bus.mem_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
        if (bus.err_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_illegal); end
        if (bus.wrapped !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrapped: got %b want 0", bus.wrapped); end
    endtask

    task automatic test_mov();
        do_reset();
        bus.mem_ready = 1'b1;
        send(mk(OP_MOV, 3'd3, 3'd5, 4'd0, 8'h00), "mov");
        @(negedge clk);
        total += 2;
        if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b1) begin
            bad++; $display("[TB] FAIL mov_busy: in_ready=%b mem_we=%b want 0/1", bus.in_ready, bus.mem_we);
        end
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h005D) begin
            bad++; $display("[TB] FAIL mov_port: got %h%h want 005D", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        total += 2;
        if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++; $display("[TB] FAIL mov_ready_back: in_ready=%b mem_we=%b want 1/0", bus.in_ready, bus.mem_we);
        end
        if (obs_q.size() != 1 || obs_q[0] !== 16'h005D) begin
            bad++; $display("[TB] FAIL mov_writes: count=%0d first=%h want 1 write 005D", obs_q.size(),
                            obs_q.size() > 0 ? obs_q[0] : 16'hxxxx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldi();
        do_reset();
        bus.mem_ready = 1'b1;
        send(mk(OP_LDI, 3'd0, 3'd2, 4'd0, 8'hA5), "ldi");
        wait_idle("ldi");
        total += 2;
        if (obs_q.size() != 2 || obs_q[0] !== 16'h0092 || obs_q[1] !== 16'h01A5) begin
            bad++; $display("[TB] FAIL ldi_writes: count=%0d want 2 writes 0092,01A5", obs_q.size());
        end
        if (bus.mem_addr !== 8'h02) begin bad++; $display("[TB] FAIL ldi_addr: got %h want 02", bus.mem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.mem_ready = 1'b0;
        send(mk(OP_ALU, 3'd0, 3'd0, ALU_SUB, 8'h00), "stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h81) begin
                bad++; $display("[TB] FAIL stall_hold%0d: we=%b addr=%h data=%h want 1/00/81", i,
                                bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        wait_idle("stall");
        total += 2;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h0081) begin
            bad++; $display("[TB] FAIL stall_writes: count=%0d want 1 write 0081", obs_q.size());
        end
        if (bus.mem_addr !== 8'h01) begin bad++; $display("[TB] FAIL stall_addr: got %h want 01", bus.mem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.mem_ready = 1'b1;
        bus.set_addr  = 1'b1;
        bus.addr_in   = 8'hFF;
        drive_fields(mk(OP_NOP, 3'd0, 3'd0, 4'd0, 8'h00));
        bus.in_valid  = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL setaddr_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.set_addr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_addr !== 8'hFF || bus.mem_we !== 1'b0) begin
            bad++; $display("[TB] FAIL setaddr_load: addr=%h we=%b want FF/0", bus.mem_addr, bus.mem_we);
        end
        @(posedge clk); #1;
        send(mk(OP_JMP, 3'd0, 3'd0, 4'd0, 8'h10), "wrap");
        wait_idle("wrap");
        total += 3;
        if (obs_q.size() != 2 || obs_q[0] !== 16'hFFC9 || obs_q[1] !== 16'h0010) begin
            bad++; $display("[TB] FAIL wrap_writes: count=%0d want 2 writes FFC9,0010", obs_q.size());
        end
        if (bus.wrapped !== 1'b1) begin bad++; $display("[TB] FAIL wrap_flag: got %b want 1", bus.wrapped); end
        if (bus.mem_addr !== 8'h01) begin bad++; $display("[TB] FAIL wrap_addr: got %h want 01", bus.mem_addr); end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.mem_ready = 1'b1;
        send(mk(8'h77, 3'd1, 3'd1, 4'd1, 8'h11), "illegal");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL illegal_idle%0d: we=%b ready=%b want 0/1", i, bus.mem_we, bus.in_ready);
            end
        end
        total += 2;
        if (bus.err_illegal !== 1'b1) begin bad++; $display("[TB] FAIL illegal_flag: got %b want 1", bus.err_illegal); end
        if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL illegal_writes: count=%0d want 0", obs_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mem_ready = 1'b1;
        send(mk(OP_LDI, 3'd0, 3'd1, 4'd0, 8'h3C), "rstmid");
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h3C) begin
            bad++; $display("[TB] FAIL rstmid_imm: we=%b data=%h want 1/3C", bus.mem_we, bus.mem_wdata);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00) begin
            bad++; $display("[TB] FAIL rstmid_async: we=%b addr=%h want 0/00", bus.mem_we, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_quiet%0d: we=%b want 0", i, bus.mem_we); end
        end
        total++;
        if (obs_q.size() != 1) begin bad++; $display("[TB] FAIL rstmid_writes: count=%0d want 1", obs_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        tuple_t cur;
        int sent = 0;
        int cycles = 0;
        bit acc;
        do_reset();
        bus.set_addr = 1'b1;
        bus.addr_in  = 8'hF0;
        @(posedge clk); #1;
        bus.set_addr = 1'b0;
        m_addr = 8'hF0; m_wrapped = 1'b0; m_err = 1'b0;
        exp_q.delete();
        cur = mk(8'h00, 3'd0, 3'd0, 4'd0, 8'h00);
        while (sent < 40 && cycles < 4000) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                cur = mk(8'($urandom_range(0, 17)), 3'($urandom), 3'($urandom), 4'($urandom), 8'($urandom));
                drive_fields(cur);
                bus.in_valid = 1'b1;
            end
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            acc = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                model_accept(cur);
                acc = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
            if (acc) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        total++;
        if (sent < 40) begin bad++; $display("[TB] FAIL rand_budget: sent=%0d want 40", sent); end
        bus.mem_ready = 1'b1;
        wait_idle("rand");
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("[TB] FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("[TB] FAIL rand_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        total += 3;
        if (bus.wrapped !== m_wrapped) begin bad++; $display("[TB] FAIL rand_wrapped: got %b want %b", bus.wrapped, m_wrapped); end
        if (bus.err_illegal !== m_err) begin bad++; $display("[TB] FAIL rand_err: got %b want %b", bus.err_illegal, m_err); end
        if (bus.mem_addr !== m_addr) begin bad++; $display("[TB] FAIL rand_addr: got %h want %h", bus.mem_addr, m_addr); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_mov();
        test_ldi();
        test_stall();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
